// File: rtl/maf_addend_negate.sv
// Pre-adder addend negation for the MAF datapath.
// Turns the aligned addend magnitude plus operand signs into the two's-complement
// operand for the 75-bit main adder. Handles double, dual-single and single
// packings. A 2-entry valid/ready buffer sits on the output so that adder-side
// backpressure never drops an operand.
module maf_addend_negate #(
    parameter int W_OUT = 75            // only 75 is supported; lane slices below are fixed
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cont,
    input  logic [W_OUT-2:0] c_mag,
    input  logic             S_A,
    input  logic             S_B,
    input  logic             S_C,
    input  logic             S_A_H,
    input  logic             S_B_H,
    input  logic             S_C_H,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] p_c,
    output logic             eff_sub,
    output logic             eff_sub_h,
    output logic [2:0]       cont_o,
    output logic             mode_err
);

    typedef struct packed {
        logic [W_OUT-1:0] p_c;
        logic             eff_sub;
        logic             eff_sub_h;
        logic [2:0]       cont;
        logic             mode_err;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry;
    logic   rst_n_q;
    logic   push, pop;

    logic             es, esh;
    logic [W_OUT-1:0] neg_dbl;
    logic [35:0]      neg_hi, neg_lo;
    logic [48:0]      neg_sgl;

    // Conditional negates for every packing; each lane negates on its own width so
    // carries stay inside the lane. The mode mux then picks and packs the result.
    always_comb begin
        es      = S_A ^ S_B ^ S_C;
        esh     = S_A_H ^ S_B_H ^ S_C_H;
        neg_dbl = ({1'b0, c_mag} ^ {W_OUT{es}}) + W_OUT'(es);
        neg_hi  = ({1'b0, c_mag[70:36]} ^ {36{esh}}) + 36'(esh);
        neg_lo  = ({1'b0, c_mag[34:0]} ^ {36{es}}) + 36'(es);
        neg_sgl = ({1'b0, c_mag[73:26]} ^ {49{es}}) + 49'(es);

        new_entry           = '0;
        new_entry.cont      = cont;
        case (cont)
            3'b000: begin
                new_entry.p_c     = neg_dbl;
                new_entry.eff_sub = es;
            end
            3'b001: begin
                // high sign lands at bit 72, low sign at bit 35; bit 36 is a lane gap
                new_entry.p_c       = {2'b00, neg_hi, 1'b0, neg_lo};
                new_entry.eff_sub   = es;
                new_entry.eff_sub_h = esh;
            end
            3'b010: begin
                new_entry.p_c     = {neg_sgl, 26'd0};
                new_entry.eff_sub = es;
            end
            default: begin
                // illegal code still travels through the buffer so order is kept
                new_entry.mode_err = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q != FULL) & rst_n_q;
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Buffer next-state and entry movement; head is always the oldest entry.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = new_entry;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_entry;
                end else if (push) begin
                    state_d = FULL;
                    tail_d  = new_entry;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State, storage and the post-reset ready gate; reset discards all entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rst_n_q <= 1'b1;
        end
    end

    assign p_c       = head_q.p_c;
    assign eff_sub   = head_q.eff_sub;
    assign eff_sub_h = head_q.eff_sub_h;
    assign cont_o    = head_q.cont;
    assign mode_err  = head_q.mode_err;

endmodule

// File: tb/tb_maf_addend_negate.sv
// Directed testbench for maf_addend_negate with hand-computed expectations.
module tb_maf_addend_negate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  cont;
    logic [73:0] c_mag;
    logic        S_A, S_B, S_C, S_A_H, S_B_H, S_C_H;
    logic        out_valid;
    logic        out_ready;
    logic [74:0] p_c;
    logic        eff_sub;
    logic        eff_sub_h;
    logic [2:0]  cont_o;
    logic        mode_err;

    int n_cmp = 0;
    int n_err = 0;

    maf_addend_negate #(.W_OUT(75)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .cont(cont), .c_mag(c_mag),
        .S_A(S_A), .S_B(S_B), .S_C(S_C),
        .S_A_H(S_A_H), .S_B_H(S_B_H), .S_C_H(S_C_H),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_c(p_c), .eff_sub(eff_sub), .eff_sub_h(eff_sub_h),
        .cont_o(cont_o), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [73:0] m,
                         input logic sa, input logic sb, input logic sc,
                         input logic sah, input logic sbh, input logic sch);
        cont = c; c_mag = m;
        S_A = sa; S_B = sb; S_C = sc;
        S_A_H = sah; S_B_H = sbh; S_C_H = sch;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'b000, 74'd0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (p_c !== 75'd0) begin n_err++; $display("FAIL reset p_c: got %h expected 0", p_c); end
        n_cmp++; if ({eff_sub, eff_sub_h, mode_err, cont_o} !== 6'd0) begin n_err++; $display("FAIL reset flags: got %b expected 000000", {eff_sub, eff_sub_h, mode_err, cont_o}); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset release in_ready: got %b expected 1", in_ready); end
        $display("reset done");
    endtask

    task automatic test_double();
        out_ready = 1'b1;
        // negate of 1: all ones; high-lane signs must not leak into eff_sub_h
        drive(3'b000, 74'd1, 0, 0, 1, 1, 0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dbl_neg out_valid: got %b expected 1", out_valid); end
        n_cmp++; if (p_c !== 75'h7FFFFFFFFFFFFFFFFFF) begin n_err++; $display("FAIL dbl_neg p_c: got %h expected 7ffffffffffffffffff", p_c); end
        n_cmp++; if (eff_sub !== 1'b1 || eff_sub_h !== 1'b0) begin n_err++; $display("FAIL dbl_neg eff: got %b%b expected 10", eff_sub, eff_sub_h); end
        $display("txn double neg: p_c=%h", p_c);
        tick();
        drive(3'b000, 74'd1, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (p_c !== 75'd1 || eff_sub !== 1'b0) begin n_err++; $display("FAIL dbl_pos p_c/eff: got %h/%b expected 1/0", p_c, eff_sub); end
        $display("txn double pos: p_c=%h", p_c);
        tick();
        // zero magnitude with subtract wraps to zero; two negative signs cancel
        drive(3'b000, 74'd0, 1, 1, 1, 0, 0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (p_c !== 75'd0 || eff_sub !== 1'b1) begin n_err++; $display("FAIL dbl_zero p_c/eff: got %h/%b expected 0/1", p_c, eff_sub); end
        $display("txn double zero: p_c=%h", p_c);
        tick();
    endtask

    task automatic test_dual();
        logic [74:0] exp;
        out_ready = 1'b1;
        // bits 73 and 35 set as junk that must be ignored
        drive(3'b001, (74'd1 << 73) | (74'd5 << 36) | (74'd1 << 35) | 74'd3, 0, 0, 0, 1, 0, 0);
        exp = {2'b00, 36'hFFFFFFFFB, 1'b0, 36'h3};
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (p_c !== exp) begin n_err++; $display("FAIL dual p_c: got %h expected %h", p_c, exp); end
        n_cmp++; if (eff_sub !== 1'b0 || eff_sub_h !== 1'b1 || cont_o !== 3'b001) begin n_err++; $display("FAIL dual flags: got %b%b %b expected 01 001", eff_sub, eff_sub_h, cont_o); end
        $display("txn dual: p_c=%h", p_c);
        tick();
        // high lane zero with subtract must not borrow from the low lane
        drive(3'b001, 74'd3, 0, 0, 0, 0, 1, 0);
        exp = {2'b00, 36'h0, 1'b0, 36'h3};
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (p_c !== exp) begin n_err++; $display("FAIL dual_zero p_c: got %h expected %h", p_c, exp); end
        $display("txn dual zero-high: p_c=%h", p_c);
        tick();
        // low lane negate of 3 must not carry into the high lane
        drive(3'b001, (74'd2 << 36) | 74'd3, 1, 0, 0, 0, 0, 0);
        exp = {2'b00, 36'h2, 1'b0, 36'hFFFFFFFFD};
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (p_c !== exp) begin n_err++; $display("FAIL dual_lo p_c: got %h expected %h", p_c, exp); end
        $display("txn dual neg-low: p_c=%h", p_c);
        tick();
    endtask

    task automatic test_single();
        logic [74:0] exp;
        out_ready = 1'b1;
        drive(3'b010, (74'd1 << 26) | 74'h3FFFFFF, 0, 1, 0, 0, 0, 0);
        exp = {49'h1FFFFFFFFFFFF, 26'd0};
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (p_c !== exp) begin n_err++; $display("FAIL single p_c: got %h expected %h", p_c, exp); end
        n_cmp++; if (eff_sub !== 1'b1 || eff_sub_h !== 1'b0) begin n_err++; $display("FAIL single eff: got %b%b expected 10", eff_sub, eff_sub_h); end
        $display("txn single: p_c=%h", p_c);
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(3'b011, {74{1'b1}}, 1, 0, 0, 1, 0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || p_c !== 75'd0) begin n_err++; $display("FAIL illegal valid/p_c: got %b/%h expected 1/0", out_valid, p_c); end
        n_cmp++; if (mode_err !== 1'b1 || eff_sub !== 1'b0 || eff_sub_h !== 1'b0 || cont_o !== 3'b011) begin n_err++; $display("FAIL illegal flags: got err=%b es=%b esh=%b cont=%b expected 1 0 0 011", mode_err, eff_sub, eff_sub_h, cont_o); end
        $display("txn illegal: p_c=%h mode_err=%b", p_c, mode_err);
        tick();
        drive(3'b000, 74'd2, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (mode_err !== 1'b0 || p_c !== 75'd2) begin n_err++; $display("FAIL post_illegal: got err=%b p_c=%h expected 0/2", mode_err, p_c); end
        $display("txn post-illegal: p_c=%h mode_err=%b", p_c, mode_err);
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(3'b000, 74'd1, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1; tick();
        n_cmp++; if (in_ready !== 1'b1 || p_c !== 75'd1) begin n_err++; $display("FAIL bp first: got rdy=%b p_c=%h expected 1/1", in_ready, p_c); end
        c_mag = 74'd2; tick();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || p_c !== 75'd1) begin n_err++; $display("FAIL bp full: got rdy=%b v=%b p_c=%h expected 0/1/1", in_ready, out_valid, p_c); end
        c_mag = 74'd3; tick();
        n_cmp++; if (in_ready !== 1'b0 || p_c !== 75'd1) begin n_err++; $display("FAIL bp hold: got rdy=%b p_c=%h expected 0/1", in_ready, p_c); end
        out_ready = 1'b1; tick();
        n_cmp++; if (out_valid !== 1'b1 || p_c !== 75'd2 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp drain2: got v=%b p_c=%h rdy=%b expected 1/2/1", out_valid, p_c, in_ready); end
        $display("txn bp out: p_c=%h", p_c);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || p_c !== 75'd3) begin n_err++; $display("FAIL bp drain3: got v=%b p_c=%h expected 1/3", out_valid, p_c); end
        $display("txn bp out: p_c=%h", p_c);
        in_valid = 1'b0; tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 74'(10 + i), 0, 0, 0, 0, 0, 0);
            tick();
            n_cmp++; if (out_valid !== 1'b1 || p_c !== 75'(10 + i)) begin n_err++; $display("FAIL b2b[%0d]: got v=%b p_c=%h expected 1/%h", i, out_valid, p_c, 75'(10 + i)); end
            $display("txn b2b[%0d]: p_c=%h", i, p_c);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(3'b000, 74'd4, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1; tick();
        c_mag = 74'd5; tick();
        in_valid = 1'b0;
        rst_n = 1'b0; tick();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || p_c !== 75'd0) begin n_err++; $display("FAIL stall_rst: got v=%b rdy=%b p_c=%h expected 0/0/0", out_valid, in_ready, p_c); end
        rst_n = 1'b1; tick();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL stall_rel: got rdy=%b v=%b expected 1/0", in_ready, out_valid); end
        out_ready = 1'b1;
        drive(3'b000, 74'd7, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || p_c !== 75'd7) begin n_err++; $display("FAIL stall_fresh: got v=%b p_c=%h expected 1/7", out_valid, p_c); end
        $display("txn after reset: p_c=%h", p_c);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_nodup: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_double();
        test_dual();
        test_single();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
